// File: rtl/ctrl_enchimento_multibico_if.sv
// ctrl_enchimento_multibico_if: handshake/sensor/actuator bundle between the master sequencer and the filling controller
//  master: drives cmd_iniciar, sensor_nivel, garrafa_concluida, ack_erro; observes the rest
//  slave : the controller side, drives esteira, valvula_ativa, tarefa_concluida, erro_timeout, estado, cont_lotes
interface ctrl_enchimento_multibico_if #(
  parameter int N_BICOS = 2,
  parameter int CONT_W  = 16
);
  logic               cmd_iniciar;
  logic [N_BICOS-1:0] sensor_nivel;
  logic               garrafa_concluida;
  logic               ack_erro;
  logic               esteira;
  logic [N_BICOS-1:0] valvula_ativa;
  logic               tarefa_concluida;
  logic               erro_timeout;
  logic [2:0]         estado;
  logic [CONT_W-1:0]  cont_lotes;
  modport master (
    output cmd_iniciar, sensor_nivel, garrafa_concluida, ack_erro,
    input  esteira, valvula_ativa, tarefa_concluida, erro_timeout, estado, cont_lotes
  );
  modport slave (
    input  cmd_iniciar, sensor_nivel, garrafa_concluida, ack_erro,
    output esteira, valvula_ativa, tarefa_concluida, erro_timeout, estado, cont_lotes
  );
endinterface

// File: rtl/ctrl_enchimento_multibico.sv
// ctrl_enchimento_multibico: Moore controller for a multi-nozzle bottle-filling station
//  clk   : system clock
//  reset : asynchronous, active-high
//  bus   : slave side of ctrl_enchimento_multibico_if (commands, level sensors, valves, status, batch counter)
module ctrl_enchimento_multibico #(
  parameter int N_BICOS    = 2,
  parameter int T_ESTEIRA  = 50000000,
  parameter int DEB_CICLOS = 16,
  parameter int T_TIMEOUT  = 250000000,
  parameter int CONT_W     = 16
) (
  input logic clk,
  input logic reset,
  ctrl_enchimento_multibico_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ESTEIRA   = 3'd1,
    ENCHENDO  = 3'd2,
    CONCLUIDO = 3'd3,
    ERRO      = 3'd4
  } estado_t;
  localparam int T_MAX = (T_TIMEOUT > T_ESTEIRA) ? T_TIMEOUT : T_ESTEIRA;
  localparam int TW = $clog2(T_MAX + 1);
  localparam int DW = $clog2(DEB_CICLOS + 1);
  localparam logic [TW-1:0] T_EST_FIM = TW'(T_ESTEIRA - 1);
  localparam logic [TW-1:0] T_TO_FIM  = TW'(T_TIMEOUT - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CICLOS);
  estado_t            estado_q, estado_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [N_BICOS-1:0] valv_q, valv_d;
  logic [CONT_W-1:0]  cont_q, cont_d;
  logic [N_BICOS-1:0] sync1_q, sync2_q;
  logic [DW-1:0]      deb_cnt_q [N_BICOS];
  logic [DW-1:0]      deb_cnt_d [N_BICOS];
  logic [N_BICOS-1:0] deb;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      timer_q  <= '0;
      valv_q   <= '0;
      cont_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      for (int i = 0; i < N_BICOS; i++) deb_cnt_q[i] <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
      valv_q   <= valv_d;
      cont_q   <= cont_d;
      sync1_q  <= bus.sensor_nivel;
      sync2_q  <= sync1_q;
      for (int i = 0; i < N_BICOS; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end
  // saturating count of consecutive synced highs; any low sample restarts it
  always_comb begin
    for (int i = 0; i < N_BICOS; i++) begin
      deb_cnt_d[i] = !sync2_q[i] ? '0 : (deb_cnt_q[i] == DEB_MAX) ? deb_cnt_q[i] : deb_cnt_q[i] + DW'(1);
      deb[i]       = deb_cnt_q[i] >= DEB_MAX;
    end
  end
  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q + TW'(1);
    valv_d   = valv_q;
    cont_d   = cont_q;
    case (estado_q)
      IDLE: begin
        timer_d  = '0;
        estado_d = bus.cmd_iniciar ? ESTEIRA : IDLE;
      end
      ESTEIRA: begin
        if (!bus.cmd_iniciar) begin
          estado_d = IDLE;
          timer_d  = '0;
        end else if (timer_q == T_EST_FIM) begin
          estado_d = ENCHENDO;
          timer_d  = '0;
          valv_d   = '1;
        end
      end
      ENCHENDO: begin
        // closed valves stay closed; a valve closing on the timeout edge avoids ERRO
        valv_d = valv_q & ~deb;
        if (!bus.cmd_iniciar) begin
          estado_d = IDLE;
          timer_d  = '0;
          valv_d   = '0;
        end else if (valv_q == '0) begin
          estado_d = CONCLUIDO;
          timer_d  = '0;
        end else if (timer_q == T_TO_FIM && valv_d != '0) begin
          estado_d = ERRO;
          timer_d  = '0;
          valv_d   = '0;
        end
      end
      CONCLUIDO: begin
        timer_d = '0;
        if (!bus.cmd_iniciar && bus.garrafa_concluida) begin
          estado_d = IDLE;
          cont_d   = cont_q + CONT_W'(1);
        end
      end
      ERRO: begin
        timer_d  = '0;
        valv_d   = '0;
        estado_d = (bus.ack_erro && !bus.cmd_iniciar) ? IDLE : ERRO;
      end
      default: begin
        estado_d = IDLE;
        timer_d  = '0;
        valv_d   = '0;
      end
    endcase
  end
  assign bus.esteira          = estado_q == ESTEIRA;
  assign bus.tarefa_concluida = estado_q == CONCLUIDO;
  assign bus.erro_timeout     = estado_q == ERRO;
  assign bus.valvula_ativa    = valv_q;
  assign bus.estado           = estado_q;
  assign bus.cont_lotes       = cont_q;
endmodule

// File: tb/tb_ctrl_enchimento_multibico.sv
// tb_ctrl_enchimento_multibico: self-checking bench with a batch-counter scoreboard
module tb_ctrl_enchimento_multibico;
  localparam int NB = 2, TE = 10, DC = 4, TT = 100, CW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ctrl_enchimento_multibico_if #(.N_BICOS(NB), .CONT_W(CW)) bus ();
  ctrl_enchimento_multibico #(
    .N_BICOS(NB), .T_ESTEIRA(TE), .DEB_CICLOS(DC), .T_TIMEOUT(TT), .CONT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int n_vec = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] cont_mdl = '0;
  logic [CW-1:0] cont_prev = '0;
  logic [CW-1:0] e_cont;
  always @(negedge clk) begin
    if (!reset && bus.cont_lotes !== cont_prev) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL cont_unexpected: got %0d, no batch completion pending", bus.cont_lotes);
      end else begin
        e_cont = exp_q.pop_front();
        if (bus.cont_lotes !== e_cont) begin
          n_bad++;
          $display("FAIL cont_lotes: got %0d want %0d", bus.cont_lotes, e_cont);
        end
      end
    end
    cont_prev = bus.cont_lotes;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic wait_estado(input logic [2:0] s, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (bus.estado === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset();
    bus.cmd_iniciar = 0; bus.sensor_nivel = '0; bus.garrafa_concluida = 0; bus.ack_erro = 0;
    reset = 1;
    repeat (3) tick();
    n_vec++;
    if (bus.estado !== 3'd0) begin n_bad++; $display("FAIL reset_estado: got %0d want 0", bus.estado); end
    n_vec++;
    if ({bus.esteira, bus.tarefa_concluida, bus.erro_timeout} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {bus.esteira, bus.tarefa_concluida, bus.erro_timeout});
    end
    n_vec++;
    if (bus.valvula_ativa !== 2'b00) begin n_bad++; $display("FAIL reset_valves: got %b want 00", bus.valvula_ativa); end
    n_vec++;
    if (bus.cont_lotes !== 2'd0) begin n_bad++; $display("FAIL reset_cont: got %0d want 0", bus.cont_lotes); end
    reset = 0;
    tick();
  endtask
  task automatic test_esteira();
    int cnt;
    cnt = 0;
    bus.cmd_iniciar = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.esteira === 1'b1) cnt++;
      else if (cnt > 0) break;
    end
    n_vec++;
    if (cnt != TE) begin n_bad++; $display("FAIL esteira_len: got %0d cycles want %0d", cnt, TE); end
    n_vec++;
    if (bus.valvula_ativa !== 2'b11) begin n_bad++; $display("FAIL valves_open: got %b want 11", bus.valvula_ativa); end
    n_vec++;
    if (bus.estado !== 3'd2) begin n_bad++; $display("FAIL estado_enchendo: got %0d want 2", bus.estado); end
  endtask
  task automatic test_enchimento();
    int n;
    bus.sensor_nivel = 2'b01;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); n++;
      if (bus.valvula_ativa[0] === 1'b0) break;
    end
    n_vec++;
    if (n != DC + 3) begin n_bad++; $display("FAIL valve0_latency: got %0d edges want %0d", n, DC + 3); end
    n_vec++;
    if (bus.valvula_ativa[1] !== 1'b1) begin n_bad++; $display("FAIL valve1_still_open: got %b want 1", bus.valvula_ativa[1]); end
    repeat (20 - n) tick();
    bus.sensor_nivel = 2'b11;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); n++;
      if (bus.valvula_ativa[1] === 1'b0) break;
    end
    n_vec++;
    if (n != DC + 3) begin n_bad++; $display("FAIL valve1_latency: got %0d edges want %0d", n, DC + 3); end
    n_vec++;
    if (bus.tarefa_concluida !== 1'b0) begin n_bad++; $display("FAIL done_early: got %b want 0", bus.tarefa_concluida); end
    tick();
    n_vec++;
    if (bus.tarefa_concluida !== 1'b1 || bus.estado !== 3'd3) begin
      n_bad++; $display("FAIL done: got tarefa=%b estado=%0d want 1/3", bus.tarefa_concluida, bus.estado);
    end
    bus.cmd_iniciar = 0; bus.garrafa_concluida = 1;
    cont_mdl++; exp_q.push_back(cont_mdl);
    tick();
    n_vec++;
    if (bus.estado !== 3'd0) begin n_bad++; $display("FAIL back_idle: got %0d want 0", bus.estado); end
    bus.garrafa_concluida = 0; bus.sensor_nivel = '0;
    repeat (4) tick();
  endtask
  task automatic test_timeout();
    bit ok;
    int n;
    bus.cmd_iniciar = 1;
    wait_estado(3'd2, 30, ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL to_reach_enchendo: got estado %0d want 2", bus.estado); end
    bus.sensor_nivel = 2'b01;
    n = 0;
    for (int i = 0; i < 130; i++) begin
      tick(); n++;
      if (bus.erro_timeout === 1'b1) break;
      bus.sensor_nivel[1] = (n % 5) < 3;
    end
    n_vec++;
    if (n != TT) begin n_bad++; $display("FAIL timeout_len: got %0d cycles want %0d", n, TT); end
    n_vec++;
    if (bus.valvula_ativa !== 2'b00 || bus.esteira !== 1'b0) begin
      n_bad++; $display("FAIL erro_outputs: got valves=%b esteira=%b want 00/0", bus.valvula_ativa, bus.esteira);
    end
    bus.cmd_iniciar = 0; bus.ack_erro = 1; bus.sensor_nivel = '0;
    tick();
    n_vec++;
    if (bus.estado !== 3'd0 || bus.erro_timeout !== 1'b0) begin
      n_bad++; $display("FAIL ack_idle: got estado=%0d erro=%b want 0/0", bus.estado, bus.erro_timeout);
    end
    n_vec++;
    if (bus.cont_lotes !== cont_mdl) begin n_bad++; $display("FAIL cont_after_erro: got %0d want %0d", bus.cont_lotes, cont_mdl); end
    bus.ack_erro = 0;
    repeat (4) tick();
  endtask
  task automatic test_timeout_limite();
    bit ok;
    bus.cmd_iniciar = 1;
    wait_estado(3'd2, 30, ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL lim_reach_enchendo: got estado %0d want 2", bus.estado); end
    bus.sensor_nivel = 2'b01;
    for (int n = 1; n <= TT; n++) begin
      tick();
      if (n == TT - (DC + 3)) bus.sensor_nivel = 2'b11;
    end
    n_vec++;
    if (bus.erro_timeout !== 1'b0 || bus.valvula_ativa !== 2'b00) begin
      n_bad++; $display("FAIL lim_edge: got erro=%b valves=%b want 0/00", bus.erro_timeout, bus.valvula_ativa);
    end
    tick();
    n_vec++;
    if (bus.tarefa_concluida !== 1'b1 || bus.erro_timeout !== 1'b0) begin
      n_bad++; $display("FAIL lim_done: got tarefa=%b erro=%b want 1/0", bus.tarefa_concluida, bus.erro_timeout);
    end
    bus.cmd_iniciar = 0; bus.garrafa_concluida = 1;
    cont_mdl++; exp_q.push_back(cont_mdl);
    tick();
    bus.garrafa_concluida = 0; bus.sensor_nivel = '0;
    repeat (4) tick();
  endtask
  task automatic test_abort();
    bit ok;
    bus.cmd_iniciar = 1;
    repeat (5) tick();
    n_vec++;
    if (bus.esteira !== 1'b1) begin n_bad++; $display("FAIL abort_pre_esteira: got %b want 1", bus.esteira); end
    bus.cmd_iniciar = 0;
    tick();
    n_vec++;
    if ({bus.estado, bus.esteira, bus.valvula_ativa, bus.tarefa_concluida, bus.erro_timeout} !== 8'd0) begin
      n_bad++; $display("FAIL abort_esteira: got estado=%0d esteira=%b valves=%b want all 0", bus.estado, bus.esteira, bus.valvula_ativa);
    end
    repeat (2) tick();
    bus.cmd_iniciar = 1;
    wait_estado(3'd2, 30, ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL abort_reach_enchendo: got estado %0d want 2", bus.estado); end
    repeat (10) tick();
    bus.cmd_iniciar = 0;
    tick();
    n_vec++;
    if ({bus.estado, bus.esteira, bus.valvula_ativa, bus.tarefa_concluida, bus.erro_timeout} !== 8'd0) begin
      n_bad++; $display("FAIL abort_enchendo: got estado=%0d valves=%b want all 0", bus.estado, bus.valvula_ativa);
    end
    n_vec++;
    if (bus.cont_lotes !== cont_mdl) begin n_bad++; $display("FAIL abort_cont: got %0d want %0d", bus.cont_lotes, cont_mdl); end
    repeat (2) tick();
  endtask
  task automatic test_reset_async();
    bit ok;
    bus.cmd_iniciar = 1;
    wait_estado(3'd2, 30, ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL ar_reach_enchendo: got estado %0d want 2", bus.estado); end
    repeat (5) tick();
    #1 reset = 1;
    #1;
    n_vec++;
    if ({bus.estado, bus.valvula_ativa, bus.cont_lotes, bus.esteira} !== 8'd0) begin
      n_bad++; $display("FAIL async_reset: got estado=%0d valves=%b cont=%0d want all 0", bus.estado, bus.valvula_ativa, bus.cont_lotes);
    end
    cont_mdl = '0;
    bus.cmd_iniciar = 0;
    repeat (2) tick();
    reset = 0;
    tick();
  endtask
  task automatic test_back_to_back();
    bit ok;
    for (int b = 0; b < 5; b++) begin
      bus.cmd_iniciar = 1;
      wait_estado(3'd2, 30, ok);
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL b2b_enchendo[%0d]: got estado %0d want 2", b, bus.estado); end
      bus.sensor_nivel = 2'b11;
      wait_estado(3'd3, 20, ok);
      n_vec++;
      if (!ok) begin n_bad++; $display("FAIL b2b_concluido[%0d]: got estado %0d want 3", b, bus.estado); end
      bus.cmd_iniciar = 0; bus.garrafa_concluida = 1;
      cont_mdl++; exp_q.push_back(cont_mdl);
      tick();
      bus.garrafa_concluida = 0; bus.sensor_nivel = '0;
      repeat (4) tick();
    end
  endtask
  initial begin
    test_reset();
    test_esteira();
    test_enchimento();
    test_timeout();
    test_timeout_limite();
    test_abort();
    test_reset_async();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
